// File: rtl/gate_unit_arbiter.sv
// Round-robin arbiter sharing one bitwise gate unit (INV/AND2/NAND2/MUX2)
// between NREQ requesters. One grant per cycle feeds a single-entry
// result register tagged with the winning requester's index.

// Shared gate datapath: the granted request's operands pass through this
// single instance, so only one copy of the WIDTH-bit logic exists.
module gate_unit_cell #(
    parameter int WIDTH = 64
) (
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    output logic [WIDTH-1:0] y
);
    // Opcode decode: 0=INV, 1=AND2, 2=NAND2, 3=MUX2 (sel picks b).
    always_comb begin
        y = '0;
        case (op)
            2'd0:    y = ~a;
            2'd1:    y = a & b;
            2'd2:    y = ~(a & b);
            default: y = sel ? b : a;
        endcase
    end
endmodule

module gate_unit_arbiter #(
    parameter int WIDTH = 64,
    parameter int NREQ  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [2*NREQ-1:0]       req_op,
    input  logic [NREQ*WIDTH-1:0]   req_in1,
    input  logic [NREQ*WIDTH-1:0]   req_in2,
    input  logic [NREQ*WIDTH-1:0]   req_in3,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [$clog2(NREQ)-1:0] out_id,
    output logic [WIDTH-1:0]        out_data
);
    localparam int IDW = $clog2(NREQ);

    typedef struct packed {
        logic [1:0]       op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             sel;
    } gate_req_t;

    // Flat ports unpacked into per-requester packed arrays.
    gate_req_t [NREQ-1:0]             req_v;
    logic      [NREQ-1:0][WIDTH-2:0]  in3_hi;
    logic                             unused_in3;

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign req_v[i].op  = req_op[2*i +: 2];
        assign req_v[i].a   = req_in1[WIDTH*i +: WIDTH];
        assign req_v[i].b   = req_in2[WIDTH*i +: WIDTH];
        assign req_v[i].sel = req_in3[WIDTH*i];
        assign in3_hi[i]    = req_in3[WIDTH*i+1 +: WIDTH-1];
    end
    // Only bit 0 of operand 3 matters; the rest is deliberately ignored.
    assign unused_in3 = ^in3_hi;

    logic [IDW-1:0]   ptr;
    logic [IDW-1:0]   gnt_idx;
    logic             gnt_found;
    logic             stage_free;
    logic             grant;
    logic [WIDTH-1:0] gate_y;
    gate_req_t        gnt_req;

    assign stage_free = !out_valid || out_ready;
    // Reset suppresses any grant so no request is consumed during rst.
    assign grant      = gnt_found && stage_free && !rst;
    assign gnt_req    = req_v[gnt_idx];

    // Round-robin search starting at ptr, wrapping past NREQ-1 to 0.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = (int'(ptr) + k) % NREQ;
            if (!gnt_found && req_valid[idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = IDW'(idx);
            end
        end
    end

    // One-hot ready to the winner, all zero when the stage is blocked.
    always_comb begin
        req_ready = '0;
        if (grant) req_ready[gnt_idx] = 1'b1;
    end

    gate_unit_cell #(.WIDTH(WIDTH)) u_gate (
        .op  (gnt_req.op),
        .a   (gnt_req.a),
        .b   (gnt_req.b),
        .sel (gnt_req.sel),
        .y   (gate_y)
    );

    // Result register and pointer: load on grant, drain when free, else hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_id    <= '0;
            ptr       <= '0;
        end else if (grant) begin
            out_valid <= 1'b1;
            out_data  <= gate_y;
            out_id    <= gnt_idx;
            ptr       <= (gnt_idx == IDW'(NREQ-1)) ? '0 : gnt_idx + IDW'(1);
        end else if (stage_free) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_gate_unit_arbiter.sv
// Scoreboard bench for gate_unit_arbiter: a cycle model predicts req_ready
// and pushes expected {id,data} on each grant; results are popped on drain.
module tb_gate_unit_arbiter;
    localparam int W    = 64;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic                 gclk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [2*NREQ-1:0]    req_op;
    logic [NREQ*W-1:0]    req_in1, req_in2, req_in3;
    logic                 out_valid, out_ready;
    logic [IDW-1:0]       out_id;
    logic [W-1:0]         out_data;

    always #5 gclk = ~gclk;

    gate_unit_arbiter #(.WIDTH(W), .NREQ(NREQ)) dut (
        .clk(gclk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_in1(req_in1), .req_in2(req_in2), .req_in3(req_in3),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_id(out_id), .out_data(out_data)
    );

    int vectors = 0;
    int miscompares = 0;

    logic [IDW+W-1:0] sb_q[$];
    logic [IDW-1:0]   olog[$];
    logic             m_ov = 1'b0;
    int               m_ptr = 0;

    logic [NREQ-1:0]  s_rdy;
    logic             s_ov;
    logic [IDW-1:0]   s_id;
    logic [W-1:0]     s_data;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] gate_f(input logic [1:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b, input logic s);
        case (op)
            2'd0: return ~a;
            2'd1: return a & b;
            2'd2: return ~(a & b);
            default: return s ? b : a;
        endcase
    endfunction

    task automatic rnd_ops();
        for (int i = 0; i < NREQ; i++) begin
            req_in1[W*i +: W] = {$urandom, $urandom};
            req_in2[W*i +: W] = {$urandom, $urandom};
            req_in3[W*i +: W] = {$urandom, $urandom};
            req_op[2*i +: 2]  = 2'($urandom_range(0, 3));
        end
    endtask

    // Check one cycle at negedge against the model, then advance past posedge.
    task automatic cycle();
        logic [NREQ-1:0] e_rdy;
        logic            free;
        int              g;
        @(negedge gclk);
        s_rdy = req_ready; s_ov = out_valid; s_id = out_id; s_data = out_data;
        free  = !m_ov || out_ready;
        e_rdy = '0;
        g     = -1;
        if (!rst && free) begin
            for (int k = 0; k < NREQ; k++) begin
                int j;
                j = (m_ptr + k) % NREQ;
                if (g < 0 && req_valid[j]) g = j;
            end
            if (g >= 0) e_rdy[g] = 1'b1;
        end
        chk("req_ready", 128'(req_ready), 128'(e_rdy));
        chk("out_valid", 128'(out_valid), 128'(m_ov));
        if (m_ov) begin
            if (sb_q.size() == 0) chk("sb_empty", 128'(1), 128'(0));
            else chk("result", 128'({out_id, out_data}), 128'(sb_q[0]));
            if (out_ready) olog.push_back(out_id);
        end
        if (rst) begin
            sb_q.delete();
            m_ov = 1'b0; m_ptr = 0;
        end else begin
            if (m_ov && out_ready && sb_q.size() > 0) void'(sb_q.pop_front());
            if (g >= 0) begin
                sb_q.push_back({IDW'(g), gate_f(req_op[2*g +: 2], req_in1[W*g +: W],
                                                req_in2[W*g +: W], req_in3[W*g])});
                m_ov  = 1'b1;
                m_ptr = (g + 1) % NREQ;
            end else if (free) begin
                m_ov = 1'b0;
            end
        end
        @(posedge gclk); #1;
    endtask

    logic [W-1:0] op_exp[4];
    int           rr_exp[8];
    int           ws_exp[4];

    initial begin
        op_exp = '{64'h0F0F_0F0F_0F0F_0F0F, 64'hF000_F000_F000_F000,
                   64'h0FFF_0FFF_0FFF_0FFF, 64'hFF00_FF00_FF00_FF00};
        rr_exp = '{0, 1, 2, 3, 0, 1, 2, 3};
        ws_exp = '{2, 0, 2, 0};
        rst = 1'b1; out_ready = 1'b1; req_valid = '1;
        req_op = '0; req_in1 = '0; req_in2 = '0; req_in3 = '0;
        rnd_ops();
        @(posedge gclk); #1;

        // Reset held with all requests valid
        for (int c = 0; c < 2; c++) begin
            cycle();
            chk("rst_data", 128'(s_data), 128'(0));
            chk("rst_id", 128'(s_id), 128'(0));
        end
        rst = 1'b0;
        cycle();
        chk("first_grant", 128'(s_rdy), 128'(4'b0001));

        // Opcodes on req 1 alone
        req_valid = 4'b0010;
        req_in1[W*1 +: W] = 64'hF0F0_F0F0_F0F0_F0F0;
        req_in2[W*1 +: W] = 64'hFF00_FF00_FF00_FF00;
        req_in3[W*1 +: W] = 64'd1;
        for (int k = 0; k < 5; k++) begin
            if (k < 4) req_op[3:2] = 2'(k);
            else req_valid = '0;
            cycle();
            chk("op_rdy", 128'(s_rdy), 128'((k < 4) ? 4'b0010 : 4'b0000));
            if (k > 0) begin
                chk("op_data", 128'(s_data), 128'(op_exp[k-1]));
                chk("op_id", 128'(s_id), 128'(1));
                chk("op_valid", 128'(s_ov), 128'(1));
            end
        end

        // Round robin from a fresh pointer
        rst = 1'b1; cycle(); rst = 1'b0;
        olog.delete();
        req_valid = '1;
        for (int k = 0; k < 8; k++) begin rnd_ops(); cycle(); end
        req_valid = '0;
        cycle();
        chk("rr_count", 128'(olog.size()), 128'(8));
        for (int k = 0; k < 8 && k < olog.size(); k++) chk("rr_order", 128'(olog[k]), 128'(rr_exp[k]));

        // Wrap/skip: grant 2 sets ptr=3, then only 0 and 2 valid
        olog.delete();
        req_valid = 4'b0100; rnd_ops(); cycle();
        req_valid = 4'b0101;
        for (int k = 0; k < 3; k++) begin rnd_ops(); cycle(); end
        req_valid = '0; cycle();
        chk("ws_count", 128'(olog.size()), 128'(4));
        for (int k = 0; k < 4 && k < olog.size(); k++) chk("ws_order", 128'(olog[k]), 128'(ws_exp[k]));

        // Backpressure: ptr=1, grant req 1 then stall 5 cycles
        req_valid = '1; rnd_ops(); cycle();
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            rnd_ops();
            cycle();
            chk("bp_rdy", 128'(s_rdy), 128'(0));
            chk("bp_id", 128'(s_id), 128'(1));
        end
        out_ready = 1'b1;
        cycle();
        chk("bp_release", 128'(s_rdy), 128'(4'b0100));
        req_valid = '0;
        cycle();
        chk("bp_next_id", 128'(s_id), 128'(2));
        chk("bp_next_valid", 128'(s_ov), 128'(1));
        cycle();

        // Mid-operation reset discards the held result
        req_valid = '1; rnd_ops(); cycle();
        out_ready = 1'b0; cycle();
        olog.delete();
        rst = 1'b1; cycle();
        rst = 1'b0; out_ready = 1'b1; req_valid = '0;
        cycle();
        chk("mrst_valid", 128'(s_ov), 128'(0));
        req_valid = '1; rnd_ops();
        cycle();
        chk("mrst_ptr", 128'(s_rdy), 128'(4'b0001));
        req_valid = '0;
        cycle();
        cycle();
        chk("mrst_nodeliver", 128'(olog.size()), 128'(1));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/gate_unit_arbiter.md
# gate_unit_arbiter

Round-robin arbiter and sequencer sharing one WIDTH-bit bitwise gate unit (INV / AND2 / NAND2 / MUX2) between NREQ requesters. Each requester presents an opcode and up to three operands with a valid/ready handshake. One request is granted per cycle, and its result is registered into a single-entry output stage tagged with the requester index. Sits between the gate-test datapath and the C-TB drivers, and later between CPU pipeline clients contending for the logic unit.

## Interface
Parameters:
- WIDTH, 64, operand/result width in bits
- NREQ, 4, number of requesters (2..8)
- IDW, $clog2(NREQ), requester-index width (localparam)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- req_valid  in  NREQ  request i present
- req_ready  out  NREQ  request i accepted this cycle (one-hot or zero)
- req_op  in  2*NREQ  opcode of req i at bits [2i+1:2i]: 0=INV, 1=AND2, 2=NAND2, 3=MUX2
- req_in1  in  NREQ*WIDTH  operand 1 of req i at [WIDTH*i +: WIDTH]
- req_in2  in  NREQ*WIDTH  operand 2, same packing
- req_in3  in  NREQ*WIDTH  operand 3, same packing; only bit 0 used (MUX2 select)
- out_valid  out  1  result register holds a result
- out_ready  in  1  consumer takes result this cycle
- out_id  out  IDW  index of the requester that produced out_data
- out_data  out  WIDTH  result

## Operation
- Gate function of the granted request:
  - INV = ~in1
  - AND2 = in1 & in2
  - NAND2 = ~(in1 & in2)
  - MUX2 = in3[0] ? in2 : in1
- Unused operands are ignored.
- Output stage is free when out_valid==0 or out_ready==1 (same-cycle drain and refill allowed).
- Arbitration is enabled only when the output stage is free. Otherwise req_ready is all zero.
- Round-robin pointer ptr (IDW bits):
  - Search order is ptr, ptr+1, …, NREQ-1, 0, …, ptr-1.
  - The first requester with req_valid set is granted: req_ready[g]=1.
- On a grant:
  - out_data <= gate(req g), out_id <= g, out_valid <= 1.
  - ptr <= (g+1) mod NREQ; wraps from NREQ-1 to 0.
- No grant and out_ready==1 (or out_valid==0): out_valid <= 0. out_data and out_id hold their last values.
- No grant and stage not free: all output registers hold (data stable under backpressure).
- ptr changes only on a grant.
- req_ready is combinational from req_valid, ptr, out_valid and out_ready. Requesters must not make req_valid depend on req_ready.
- A requester holding req_valid with no ready keeps its operands stable. Dropping valid before grant is allowed and loses nothing.
- Reset:
  - out_valid=0, out_data=0, out_id=0, ptr=0, req_ready=0 during the rst cycle.
  - rst mid-transfer discards the held result.
  - rst wins over any simultaneous grant.

## Timing
- Latency: a request granted in cycle N produces out_valid=1 with its result in cycle N+1.
- Throughput: one result per cycle while out_ready==1 continuously.
- Fairness: a continuously valid requester is granted within NREQ grants.
- Backpressure: while out_valid==1 and out_ready==0, out_data and out_id are stable and req_ready is zero.
- First grant possible in the first cycle after rst deasserts.

## Test plan
- Reset:
  - Stimulus: rst high 2 cycles with all req_valid=1.
  - Required: req_ready=0, out_valid=0, out_data=0, out_id=0.
  - Required: after release, the first grant goes to req 0.
- Opcodes:
  - Stimulus: req 1 alone, out_ready=1, in1=0xF0F0_F0F0_F0F0_F0F0, in2=0xFF00_FF00_FF00_FF00, in3=1, ops 0..3 on consecutive cycles.
  - Required out_data: 0x0F0F_0F0F_0F0F_0F0F, 0xF000_F000_F000_F000, 0x0FFF_0FFF_0FFF_0FFF, 0xFF00_FF00_FF00_FF00.
  - Required: each result one cycle after its grant, out_id=1.
- Round robin:
  - Stimulus: all 4 requesters valid continuously, out_ready=1.
  - Required: grant order 0,1,2,3,0,1,…; one result per cycle; out_id follows the same sequence.
- Wrap/skip:
  - Stimulus: ptr=3 (after a grant to 2), only req 0 and req 2 valid.
  - Required: grant 0, then 2, then 0.
- Backpressure:
  - Stimulus: out_ready=0 for 5 cycles with a result held and all requests valid.
  - Required: req_ready=0 and out_data/out_id unchanged for the 5 cycles.
  - Stimulus: raise out_ready.
  - Required: same-cycle drain plus a new grant, next result in the following cycle.
- Mid-operation reset:
  - Stimulus: rst asserted while out_valid=1, out_ready=0.
  - Required: out_valid=0 next cycle, ptr=0, no result delivered.
